// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the MULT/MULTU sequencer and its HI/LO storage.
package mult_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE
  } state_t;

  localparam logic [1:0] MUL_SEL_HOLD = 2'b00;
  localparam logic [1:0] MUL_SEL_LOAD = 2'b01;
  localparam logic [1:0] MUL_SEL_STEP = 2'b10;

endpackage

// File: rtl/mult_hilo_regs.sv
// Architectural HI/LO registers; a product capture overrides a same-edge MTHI/MTLO write.
module mult_hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_capture,
  input  logic [WIDTH-1:0] i_prod_hi,
  input  logic [WIDTH-1:0] i_prod_lo,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_hi <= '0;
      o_lo <= '0;
    end else if (i_capture) begin
      o_hi <= i_prod_hi;
      o_lo <= i_prod_lo;
    end else begin
      if (i_hi_we) o_hi <= i_wdata;
      if (i_lo_we) o_lo <= i_wdata;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Drives the shift-add multiplier through one LOAD and WIDTH STEP cycles, then
// captures the product into HI/LO and pulses done.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic [1:0]       mul_select,
  output logic             mul_signed,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] prod_lo,
  input  logic [WIDTH-1:0] prod_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic               w_capture;

  // An abort on the CAPTURE edge must also suppress the HI/LO update.
  assign w_capture = (r_state == ST_CAPTURE) && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      mul_select <= MUL_SEL_HOLD;
      busy       <= 1'b0;
      done       <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state    <= ST_IDLE;
        r_count    <= '0;
        mul_select <= MUL_SEL_HOLD;
        busy       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              mul_a      <= op_a;
              mul_b      <= op_b;
              mul_signed <= is_signed;
              r_count    <= CNT_W'(WIDTH);
              r_state    <= ST_LOAD;
              mul_select <= MUL_SEL_LOAD;
              busy       <= 1'b1;
            end
          end
          ST_LOAD: begin
            r_state    <= ST_RUN;
            mul_select <= MUL_SEL_STEP;
          end
          ST_RUN: begin
            r_count <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
              r_state    <= ST_CAPTURE;
              mul_select <= MUL_SEL_HOLD;
            end
          end
          ST_CAPTURE: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            mul_select <= MUL_SEL_HOLD;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  mult_hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_capture),
    .i_prod_hi (prod_hi),
    .i_prod_lo (prod_lo),
    .i_hi_we   (hi_we),
    .i_lo_we   (lo_we),
    .i_wdata   (hilo_wdata),
    .o_hi      (hi),
    .o_lo      (lo)
  );

endmodule
